// File: rtl/control_sequencer.sv
// Fetch/execute sequencer around the instruction decoders: holds IR and micro-state,
// unpacks the returned control word and gates side effects to commit cycles.
module control_sequencer #(
  parameter int MAX_STEPS     = 4,
  parameter int RETIRED_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              instruction_in,
  input  logic                     imem_valid,
  input  logic [28:0]              controlWord_in,
  input  logic [1:0]               nextState_in,
  input  logic                     mem_ready,
  output logic [31:0]              instruction,
  output logic [1:0]               state,
  output logic                     fetch_req,
  output logic [1:0]               Psel,
  output logic [4:0]               DA,
  output logic [4:0]               SA,
  output logic [4:0]               SB,
  output logic [4:0]               Fsel,
  output logic                     regW,
  output logic                     ramW,
  output logic [1:0]               Dsel,
  output logic                     Bsel,
  output logic                     PCsel,
  output logic                     SL,
  output logic                     mem_stall,
  output logic [RETIRED_WIDTH-1:0] retired,
  output logic                     fault
);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] EXEC  = 1'b1;
  localparam int SW = $clog2(MAX_STEPS + 1);
  localparam logic [SW-1:0] STEP_MAX = SW'(MAX_STEPS);

  typedef struct packed {
    logic [1:0] psel;
    logic [4:0] da;
    logic [4:0] sa;
    logic [4:0] sb;
    logic [4:0] fsel;
    logic       regw;
    logic       ramw;
    logic [1:0] dsel;
    logic       bsel;
    logic       pcsel;
    logic       sl;
  } cw_t;

  cw_t           cw;
  logic [0:0]    phase;
  logic [SW-1:0] step;
  logic          exec, access, commit;

  assign cw = cw_t'(controlWord_in);

  // Reset gates exec so side effects drop in the same cycle reset is sampled low.
  assign exec      = (phase == EXEC) & reset;
  assign access    = cw.ramw | (cw.dsel == 2'b10);
  assign mem_stall = exec & access & ~mem_ready;
  assign commit    = exec & ~mem_stall;
  assign fetch_req = (phase == FETCH);

  assign DA    = exec ? cw.da    : 5'd0;
  assign SA    = exec ? cw.sa    : 5'd0;
  assign SB    = exec ? cw.sb    : 5'd0;
  assign Fsel  = exec ? cw.fsel  : 5'd0;
  assign Dsel  = exec ? cw.dsel  : 2'd0;
  assign Bsel  = exec & cw.bsel;
  assign PCsel = exec & cw.pcsel;
  // A store is held on the RAM port through stall cycles; everything else fires once.
  assign ramW  = exec & cw.ramw;
  assign Psel  = commit ? cw.psel : 2'b00;
  assign regW  = commit & cw.regw;
  assign SL    = commit & cw.sl;

  always_ff @(posedge clock) begin
    if (!reset) begin
      phase       <= FETCH;
      instruction <= 32'd0;
      state       <= 2'd0;
      step        <= '0;
      retired     <= '0;
      fault       <= 1'b0;
    end else begin
      case (phase)
        FETCH: if (imem_valid) begin
          instruction <= instruction_in;
          state       <= 2'd0;
          step        <= SW'(1);
          phase       <= EXEC;
        end
        default: if (commit) begin
          if (nextState_in != 2'd0) begin
            if (step < STEP_MAX) begin
              state <= nextState_in;
              step  <= step + SW'(1);
            end else begin
              fault <= 1'b1;
              phase <= FETCH;
              state <= 2'd0;
            end
          end else begin
            retired <= retired + {{(RETIRED_WIDTH-1){1'b0}}, 1'b1};
            phase   <= FETCH;
            state   <= 2'd0;
          end
        end
      endcase
    end
  end

endmodule
